adc_acq_sequencer: RTL and testbench

- Controller that sequences one calibrated-ADC acquisition channel for the SPGD loop. On START it waits a programmable mirror-settle time, then runs 2^LOG2_AVG back-to-back ADC_EN/ADC_DONE acquisitions. It captures each calibrated fixed-point result, averages them, and presents the mean on a valid/ready handshake to the SPGD core.
- Sits between the SPGD update FSM and the calibrated ADC datapath; it owns that datapath's enable and register-clear.

---
 rtl/adc_acq_sequencer_pkg.sv | 20 ++
 rtl/adc_acq_sequencer_accum.sv | 39 +++
 rtl/adc_acq_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_sequencer_pkg.sv
// Shared types for the ADC acquisition sequencer: FSM state encoding and
// the accumulator width helper.
package adc_acq_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CLR    = 3'd2,
        S_ACQ    = 3'd3,
        S_CAPT   = 3'd4,
        S_GAP    = 3'd5,
        S_OUTP   = 3'd6
    } acq_state_t;

    // Width that holds the sum of 2^log2_avg signed samples without overflow.
    function automatic int acc_w(input int fp_width, input int log2_avg);
        return fp_width + log2_avg;
    endfunction

endpackage

// File: rtl/adc_acq_sequencer_accum.sv
// Averaging datapath: sign-extends each calibrated sample into a wide
// accumulator and presents the floor mean (arithmetic shift right).
module adc_avg_accum
    import adc_acq_sequencer_pkg::*;
#(
    parameter int FP_WIDTH = 64,
    parameter int LOG2_AVG = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_en,
    input  logic                add_en,
    input  logic [FP_WIDTH-1:0] din,
    output logic [FP_WIDTH-1:0] mean
);

    localparam int ACC_W = acc_w(FP_WIDTH, LOG2_AVG);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] din_ext;

    // Replicate the sign bit at least once so LOG2_AVG = 0 stays legal.
    assign din_ext = {{(ACC_W - FP_WIDTH + 1){din[FP_WIDTH-1]}}, din[FP_WIDTH-2:0]};

    // Accumulator: cleared at the start of a run, one add per capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_en) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= acc_q + din_ext;
        end
    end

    // Arithmetic shift gives floor toward -inf; the mean always fits FP_WIDTH.
    assign mean = FP_WIDTH'(acc_q >>> LOG2_AVG);

endmodule

// File: rtl/adc_acq_sequencer.sv
// Sequences one calibrated-ADC channel: settle, then 2^LOG2_AVG
// enable/done acquisitions, then presents the averaged result.
//
// Result handshake: RES_VALID rises in OUTP and, together with RES_DATA and
// RES_ERR, holds stable until the cycle where RES_VALID && RES_READY; the
// transfer happens on that clock edge and RES_VALID drops the cycle after.
module adc_acq_sequencer
    import adc_acq_sequencer_pkg::*;
#(
    parameter int FP_WIDTH    = 64,
    parameter int LOG2_AVG    = 2,
    parameter int CAPT_DLY    = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                ADC_CLK,
    input  logic                REG_RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [15:0]         SETTLE_CYC,
    output logic                ADC_EN_O,
    output logic                ADC_CLR_O,
    input  logic                ADC_DONE_I,
    input  logic [FP_WIDTH-1:0] ADC_DATA_I,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [FP_WIDTH-1:0] RES_DATA,
    output logic                RES_ERR,
    output logic                BUSY,
    output logic [2:0]          state_dbg
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0] LAST_ACQ = CNT_W'((1 << LOG2_AVG) - 1);

    acq_state_t         state_q, state_d;
    logic [15:0]        settle_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [2:0]         capt_cnt;
    logic [CNT_W-1:0]   acq_cnt;
    logic               done_q;
    logic               res_err_q;
    logic               done_rise;
    logic               tmo_hit;
    logic               capt_last;
    logic               start_go;
    logic               add_en;
    logic [FP_WIDTH-1:0] mean;

    assign done_rise = ADC_DONE_I && !done_q;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign capt_last = (capt_cnt == 3'd1);
    assign start_go  = (state_q == S_IDLE) && START && !ABORT;
    assign add_en    = (state_q == S_CAPT) && capt_last && !ABORT;

    // State register.
    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (START) state_d = (SETTLE_CYC == 16'd0) ? S_CLR : S_SETTLE;
            S_SETTLE: if (settle_cnt == 16'd1) state_d = S_CLR;
            S_CLR:    state_d = S_ACQ;
            S_ACQ: begin
                if (done_rise) begin
                    state_d = S_CAPT;
                end else if (tmo_hit) begin
                    state_d = S_OUTP;
                end
            end
            S_CAPT:   if (capt_last) state_d = (acq_cnt == LAST_ACQ) ? S_OUTP : S_GAP;
            S_GAP:    if (!ADC_DONE_I) state_d = S_CLR;
            S_OUTP:   if (RES_READY) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (ABORT) begin
            state_d = S_IDLE;
        end
    end

    // Settle, timeout, capture-delay and acquisition counters plus DONE history.
    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            capt_cnt   <= '0;
            acq_cnt    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= ADC_DONE_I;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        settle_cnt <= SETTLE_CYC;
                        acq_cnt    <= '0;
                    end
                end
                S_SETTLE: settle_cnt <= settle_cnt - 16'd1;
                S_CLR:    tmo_cnt <= '0;
                S_ACQ: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (done_rise) begin
                        capt_cnt <= 3'(CAPT_DLY);
                    end
                end
                S_CAPT: begin
                    capt_cnt <= capt_cnt - 3'd1;
                    if (capt_last) begin
                        acq_cnt <= acq_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Error flag: set by an ACQ timeout, cleared by handshake, ABORT or a new run.
    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
        if (REG_RST) begin
            res_err_q <= 1'b0;
        end else if (ABORT) begin
            res_err_q <= 1'b0;
        end else if ((state_q == S_ACQ) && !done_rise && tmo_hit) begin
            res_err_q <= 1'b1;
        end else if ((state_q == S_OUTP) && RES_READY) begin
            res_err_q <= 1'b0;
        end else if (start_go) begin
            res_err_q <= 1'b0;
        end
    end

    adc_avg_accum #(
        .FP_WIDTH (FP_WIDTH),
        .LOG2_AVG (LOG2_AVG)
    ) u_accum (
        .clk    (ADC_CLK),
        .rst    (REG_RST),
        .clr_en (start_go),
        .add_en (add_en),
        .din    (ADC_DATA_I),
        .mean   (mean)
    );

    // Moore outputs decoded from the state register so reset drops them at once.
    always_comb begin
        ADC_EN_O  = (state_q == S_ACQ) || (state_q == S_CAPT);
        ADC_CLR_O = (state_q == S_CLR);
        RES_VALID = (state_q == S_OUTP);
        RES_ERR   = res_err_q;
        RES_DATA  = (RES_VALID && !res_err_q) ? mean : '0;
        BUSY      = (state_q != S_IDLE);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed/random bench for adc_acq_sequencer with a behavioural ADC model
// and an arithmetic reference for the floor mean.
module tb_adc_acq_sequencer;
    import adc_acq_sequencer_pkg::*;

    localparam int FPW   = 64;
    localparam int L2A   = 2;
    localparam int N_AVG = 1 << L2A;

    logic            adc_clk;
    logic            reg_rst;
    logic            start;
    logic            abort;
    logic [15:0]     settle_cyc;
    logic            adc_en;
    logic            adc_clr;
    logic            adc_done;
    logic [FPW-1:0]  adc_data;
    logic            res_valid;
    logic            res_ready;
    logic [FPW-1:0]  res_data;
    logic            res_err;
    logic            busy;
    logic [2:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FPW-1:0] exp_q[$];
    logic [FPW-1:0] data_q[$];
    logic [FPW-1:0] stim[N_AVG];

    int done_lat  = 20;
    int done_hold = 0;
    bit model_on  = 1'b1;
    int en_cnt;
    int hold_cnt;
    int clr_cnt   = 0;
    int bad_clr   = 0;

    adc_acq_sequencer #(
        .FP_WIDTH    (FPW),
        .LOG2_AVG    (L2A),
        .CAPT_DLY    (2),
        .TIMEOUT_CYC (50)
    ) dut (
        .ADC_CLK    (adc_clk),
        .REG_RST    (reg_rst),
        .START      (start),
        .ABORT      (abort),
        .SETTLE_CYC (settle_cyc),
        .ADC_EN_O   (adc_en),
        .ADC_CLR_O  (adc_clr),
        .ADC_DONE_I (adc_done),
        .ADC_DATA_I (adc_data),
        .RES_VALID  (res_valid),
        .RES_READY  (res_ready),
        .RES_DATA   (res_data),
        .RES_ERR    (res_err),
        .BUSY       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock.
    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    // ADC datapath model: DONE rises done_lat enabled cycles after enable,
    // stays high until done_hold cycles after the enable drops.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        en_cnt   = 0;
        hold_cnt = 0;
        forever begin
            @(negedge adc_clk);
            if (reg_rst) begin
                adc_done = 1'b0;
                en_cnt   = 0;
                hold_cnt = 0;
            end else begin
                if (adc_en) en_cnt++;
                else        en_cnt = 0;
                if (!adc_done && model_on && en_cnt == done_lat && data_q.size() > 0) begin
                    adc_done = 1'b1;
                    adc_data = data_q.pop_front();
                    hold_cnt = 0;
                end else if (adc_done && !adc_en) begin
                    hold_cnt++;
                    if (hold_cnt > done_hold) adc_done = 1'b0;
                end
            end
        end
    end

    // Clear-pulse monitor: counts pulses and pulses issued while DONE was high.
    always @(negedge adc_clk) begin
        if (adc_clr) begin
            clr_cnt++;
            if (adc_done) bad_clr++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Floor of the mean of stim[], computed with wide signed division.
    function automatic logic [63:0] ref_mean();
        logic signed [127:0] sum;
        logic signed [127:0] q;
        logic signed [127:0] r;
        sum = '0;
        for (int i = 0; i < N_AVG; i++) sum = sum + {{64{stim[i][63]}}, stim[i]};
        q = sum / 128'sd4;
        r = sum % 128'sd4;
        if (sum < 0 && r != 0) q = q - 128'sd1;
        return q[63:0];
    endfunction

    task automatic launch(input logic [15:0] s, input int lat, input int hold);
        done_lat  = lat;
        done_hold = hold;
        data_q.delete();
        for (int i = 0; i < N_AVG; i++) data_q.push_back(stim[i]);
        exp_q.push_back(ref_mean());
        settle_cyc = s;
        start = 1'b1;
        @(negedge adc_clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int busy_drop);
        busy_drop = 0;
        for (int i = 0; i < 3000; i++) begin
            if (res_valid) break;
            if (!busy) busy_drop++;
            @(negedge adc_clk);
        end
        check({tag, "_valid"}, res_valid, 1'b1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(negedge adc_clk);
        res_ready = 1'b0;
        check({tag, "_hs_valid"}, res_valid, 1'b0);
        check({tag, "_hs_err"},   res_err,   1'b0);
        check({tag, "_hs_busy"},  busy,      1'b0);
        check({tag, "_hs_state"}, state_dbg, S_IDLE);
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] s, input int lat,
                                 input int hold, input bit bp);
        int k;
        int clr0;
        int bad0;
        int busy_drop;
        int unstable;
        logic [63:0] exp;
        logic [63:0] d;
        logic        e;
        clr0 = clr_cnt;
        bad0 = bad_clr;
        launch(s, lat, hold);
        check({tag, "_busy"}, busy, 1'b1);
        k = 1;
        while (!adc_clr && k < 1000) begin
            @(negedge adc_clk);
            k++;
        end
        check({tag, "_clr_delay"}, k, s + 1);
        wait_valid(tag, busy_drop);
        exp = exp_q.pop_front();
        check({tag, "_busy_hold"}, busy_drop, 0);
        check({tag, "_data"}, res_data, exp);
        check({tag, "_err"}, res_err, 1'b0);
        check({tag, "_en_off"}, adc_en, 1'b0);
        check({tag, "_clr_pulses"}, clr_cnt - clr0, N_AVG);
        check({tag, "_clr_done_low"}, bad_clr - bad0, 0);
        if (bp) begin
            d = res_data;
            e = res_err;
            unstable = 0;
            for (int i = 0; i < 30; i++) begin
                start = (i == 10);
                @(negedge adc_clk);
                if (!res_valid || res_data !== d || res_err !== e) unstable++;
            end
            start = 1'b0;
            check({tag, "_bp_stable"}, unstable, 0);
        end
        handshake(tag);
        if (bp) begin
            repeat (3) @(negedge adc_clk);
            check({tag, "_no_queued_start"}, busy, 1'b0);
        end
    endtask

    initial begin
        int en_cycles;
        int guard;
        reg_rst    = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        settle_cyc = '0;
        res_ready  = 1'b0;

        // Reset state.
        repeat (3) @(negedge adc_clk);
        check("rst_en",    adc_en,    1'b0);
        check("rst_clr",   adc_clr,   1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data",  res_data,  64'd0);
        check("rst_err",   res_err,   1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_state", state_dbg, S_IDLE);
        reg_rst = 1'b0;
        @(negedge adc_clk);
        check("post_rst_busy", busy, 1'b0);

        // Basic average 100..400.
        stim[0] = 64'd100; stim[1] = 64'd200; stim[2] = 64'd300; stim[3] = 64'd400;
        run_and_check("basic", 16'd10, 20, 0, 1'b0);

        // Signed floor.
        stim[0] = -64'sd3; stim[1] = -64'sd4; stim[2] = -64'sd4; stim[3] = -64'sd4;
        run_and_check("neg_floor", 16'd2, 7, 0, 1'b0);

        // Maximum positive, no overflow.
        for (int i = 0; i < N_AVG; i++) stim[i] = 64'h7FFF_FFFF_FFFF_FFFF;
        run_and_check("max_pos", 16'd1, 3, 0, 1'b0);

        // Most negative values.
        for (int i = 0; i < N_AVG; i++) stim[i] = 64'h8000_0000_0000_0000 + 64'(i);
        run_and_check("max_neg", 16'd4, 5, 0, 1'b0);

        // Random data, settle and ADC latency.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_AVG; i++) stim[i] = {$urandom, $urandom};
            run_and_check("random", 16'($urandom_range(0, 15)), $urandom_range(1, 30), 0, 1'b0);
        end

        // Timeout: DONE never arrives.
        model_on = 1'b0;
        settle_cyc = 16'd0;
        start = 1'b1;
        @(negedge adc_clk);
        start = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < 500; i++) begin
            if (res_valid) break;
            if (adc_en) en_cycles++;
            @(negedge adc_clk);
        end
        check("tmo_en_cycles", en_cycles, 50);
        check("tmo_valid", res_valid, 1'b1);
        check("tmo_err", res_err, 1'b1);
        check("tmo_data", res_data, 64'd0);
        check("tmo_en_off", adc_en, 1'b0);
        handshake("tmo");
        model_on = 1'b1;

        // Backpressure with an ignored START.
        stim[0] = 64'd11; stim[1] = 64'd22; stim[2] = 64'd33; stim[3] = 64'd44;
        run_and_check("bp", 16'd3, 6, 0, 1'b1);

        // DONE held high through GAP, zero settle.
        stim[0] = 64'd5; stim[1] = 64'd6; stim[2] = 64'd7; stim[3] = 64'd9;
        run_and_check("done_hold", 16'd0, 4, 5, 1'b0);

        // ABORT in ACQ, then a clean run.
        stim[0] = 64'd1000; stim[1] = 64'd1000; stim[2] = 64'd1000; stim[3] = 64'd1000;
        launch(16'd3, 20, 0);
        void'(exp_q.pop_front());
        guard = 0;
        while (!adc_en && guard < 200) begin
            @(negedge adc_clk);
            guard++;
        end
        check("abort_reached_acq", adc_en, 1'b1);
        repeat (5) @(negedge adc_clk);
        abort = 1'b1;
        @(negedge adc_clk);
        abort = 1'b0;
        check("abort_en", adc_en, 1'b0);
        check("abort_clr", adc_clr, 1'b0);
        check("abort_valid", res_valid, 1'b0);
        check("abort_state", state_dbg, S_IDLE);
        stim[0] = 64'd8; stim[1] = 64'd8; stim[2] = 64'd16; stim[3] = 64'd0;
        run_and_check("after_abort", 16'd2, 9, 0, 1'b0);

        // REG_RST in CAPT, then a clean run.
        stim[0] = 64'd777; stim[1] = 64'd777; stim[2] = 64'd777; stim[3] = 64'd777;
        launch(16'd1, 5, 0);
        void'(exp_q.pop_front());
        guard = 0;
        while (state_dbg != S_CAPT && guard < 200) begin
            @(negedge adc_clk);
            guard++;
        end
        check("rst_mid_reached_capt", state_dbg, S_CAPT);
        check("rst_mid_en_before", adc_en, 1'b1);
        reg_rst = 1'b1;
        #1;
        check("rst_mid_en", adc_en, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_state", state_dbg, S_IDLE);
        @(negedge adc_clk);
        reg_rst = 1'b0;
        @(negedge adc_clk);
        stim[0] = -64'sd10; stim[1] = 64'd3; stim[2] = 64'd4; stim[3] = 64'd1;
        run_and_check("after_rst", 16'd5, 12, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
